// File: rtl/multicycle_control_if.sv
// Control/status bundle between multicycle_control (master) and the RV64 datapath (slave).
// Defining CONTROL_RETIRE_COUNT_EN adds the retired-instruction counter signal.
interface multicycle_control_if #(
    parameter int unsigned ALU_OP_W = 3
);
    logic [31:0]         instruction;
    logic                alu_zero;
    logic                imem_ready;
    logic                dmem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                pc_source;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                load_a_out;
    logic                load_reg_a;
    logic                load_reg_b;
    logic                reg_write;
    logic                mem_to_reg;
    logic                imem_read;
    logic                ir_write;
    logic                dmem_req;
    logic                dmem_op;
    logic                load_mdr;
    logic                illegal;
    logic [3:0]          state_out;
`ifdef CONTROL_RETIRE_COUNT_EN
    logic [31:0]         retired;
`endif

    modport master (
        input  instruction, alu_zero, imem_ready, dmem_ready,
        output pc_write, pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
               load_a_out, load_reg_a, load_reg_b, reg_write, mem_to_reg,
               imem_read, ir_write, dmem_req, dmem_op, load_mdr, illegal, state_out
`ifdef CONTROL_RETIRE_COUNT_EN
        , output retired
`endif
    );

    modport slave (
        output instruction, alu_zero, imem_ready, dmem_ready,
        input  pc_write, pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
               load_a_out, load_reg_a, load_reg_b, reg_write, mem_to_reg,
               imem_read, ir_write, dmem_req, dmem_op, load_mdr, illegal, state_out
`ifdef CONTROL_RETIRE_COUNT_EN
        , input retired
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV64 subset datapath: fetch/decode/execute/memory/writeback
// with bounded memory waits and an illegal-instruction trap. Optional macro: CONTROL_RETIRE_COUNT_EN.
module multicycle_control #(
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);
    // ALU operation codes shared with the operations package
    localparam logic [ALU_OP_W-1:0] ALU_SUM  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_LOAD = ALU_OP_W'(3);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        START    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        EXEC_R   = 4'd4,
        EXEC_I   = 4'd5,
        EXEC_U   = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        MEM_LD   = 4'd9,
        MEM_SD   = 4'd10,
        LD_WB    = 4'd11,
        TRAP     = 4'd15
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [CNT_W-1:0] waitCnt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             waiting;
    logic             awaitedReady;
    logic             timedOut;
    logic             unusedInstr;

    assign opcode        = bus.instruction[6:0];
    assign funct3        = bus.instruction[14:12];
    assign funct7b5      = bus.instruction[30];
    assign unusedInstr   = ^{bus.instruction[31], bus.instruction[29:15], bus.instruction[11:7]};
    assign waiting       = (state == FETCH) || (state == MEM_LD) || (state == MEM_SD);
    assign awaitedReady  = (state == FETCH) ? bus.imem_ready : bus.dmem_ready;
    assign timedOut      = (MEM_TIMEOUT != 0) && (waitCnt == CNT_W'(MEM_TIMEOUT));
    assign bus.state_out = state;

    // State register and wait counter; the counter restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= START;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            if (nextState != state) begin
                waitCnt <= '0;
            end else if (waiting && !awaitedReady && (waitCnt != '1)) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        nextState         = state;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = ALU_SUM;
        bus.load_a_out    = 1'b0;
        bus.load_reg_a    = 1'b0;
        bus.load_reg_b    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.imem_read     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.dmem_op       = 1'b0;
        bus.load_mdr      = 1'b0;
        bus.illegal       = 1'b0;
        case (state)
            START: nextState = FETCH;
            FETCH: begin
                bus.imem_read = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_write  = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.alu_src_b = 2'd1;
                    nextState     = DECODE;
                end else if (timedOut) begin
                    nextState = TRAP;
                end
            end
            // Branch target is precomputed here while the register file is read
            DECODE: begin
                bus.load_reg_a = 1'b1;
                bus.load_reg_b = 1'b1;
                bus.load_a_out = 1'b1;
                bus.alu_src_b  = 2'd3;
                case (opcode)
                    OPC_LOAD, OPC_STORE: nextState = MEM_ADDR;
                    OPC_OPIMM:           nextState = EXEC_I;
                    OPC_OP:              nextState = EXEC_R;
                    OPC_LUI:             nextState = EXEC_U;
                    OPC_BRANCH:          nextState = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    default:             nextState = TRAP;
                endcase
            end
            MEM_ADDR: begin
                bus.load_a_out = 1'b1;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'd2;
                nextState      = (opcode == OPC_LOAD) ? MEM_LD : MEM_SD;
            end
            MEM_LD: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ready) begin
                    bus.load_mdr = 1'b1;
                    nextState    = LD_WB;
                end else if (timedOut) begin
                    nextState = TRAP;
                end
            end
            MEM_SD: begin
                bus.dmem_req = 1'b1;
                bus.dmem_op  = 1'b1;
                if (bus.dmem_ready) begin
                    nextState = FETCH;
                end else if (timedOut) begin
                    nextState = TRAP;
                end
            end
            LD_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                nextState      = FETCH;
            end
            EXEC_R: begin
                bus.alu_src_a  = 1'b1;
                bus.load_a_out = 1'b1;
                if (funct3 == 3'b000) begin
                    bus.alu_op = funct7b5 ? ALU_SUB : ALU_SUM;
                end else begin
                    bus.alu_op = ALU_OP_W'(funct3);
                end
                nextState = ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'd2;
                bus.alu_op     = ALU_OP_W'(funct3);
                bus.load_a_out = 1'b1;
                nextState      = ALU_WB;
            end
            EXEC_U: begin
                bus.alu_src_b  = 2'd2;
                bus.alu_op     = ALU_LOAD;
                bus.load_a_out = 1'b1;
                nextState      = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                nextState     = FETCH;
            end
            // funct3[0] distinguishes BNE from BEQ
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_source     = 1'b1;
                bus.pc_write_cond = funct3[0] ? !bus.alu_zero : bus.alu_zero;
                nextState         = FETCH;
            end
            TRAP:    bus.illegal = 1'b1;
            default: nextState = START;
        endcase
    end

`ifdef CONTROL_RETIRE_COUNT_EN
    logic retire;

    assign retire = (nextState == FETCH) &&
                    ((state == LD_WB) || (state == MEM_SD) || (state == ALU_WB) || (state == BRANCH));

    // Count of instructions that completed and returned to fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.retired <= '0;
        end else if (retire) begin
            bus.retired <= bus.retired + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized instruction
// streams checked against an instruction-level path model.
module tb_multicycle_control;
    localparam int unsigned ALU_OP_W    = 3;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam logic [2:0]  OP_SUM      = 3'd0;
    localparam logic [2:0]  OP_SUB      = 3'd2;
    localparam logic [2:0]  OP_LOAD     = 3'd3;

    localparam int S_START = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_EXEC_R = 4,
                   S_EXEC_I = 5, S_EXEC_U = 6, S_ALU_WB = 7, S_BRANCH = 8, S_MEM_LD = 9,
                   S_MEM_SD = 10, S_LD_WB = 11, S_TRAP = 15;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011,
                           OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111, OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LD   = {12'd8, 5'd1, 3'b011, 5'd2, 7'b0000011};
    localparam logic [31:0] I_SD   = {7'd0, 5'd2, 5'd1, 3'b011, 5'd0, 7'b0100011};
    localparam logic [31:0] I_BEQ  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
    localparam logic [31:0] I_BNE  = {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   retiredModel = 0;
    int   pathState[$];
    bit   pathLast[$];

    multicycle_control_if #(.ALU_OP_W(ALU_OP_W)) bus ();

    multicycle_control #(
        .ALU_OP_W(ALU_OP_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] actualCtl();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.load_a_out, bus.load_reg_a, bus.load_reg_b, bus.reg_write,
                bus.mem_to_reg, bus.imem_read, bus.ir_write, bus.dmem_req, bus.dmem_op,
                bus.load_mdr, bus.illegal};
    endfunction

    // Expected control word for one cycle, straight from the per-state behaviour table
    function automatic logic [19:0] expectedCtl(int st, bit last, bit zero, logic [31:0] ir);
        logic pcW, pcWC, pcS, srcA, lao, lra, lrb, rw, m2r, imr, irw, dreq, dop, lmdr, ill;
        logic [1:0] srcB;
        logic [2:0] op;
        logic [2:0] f3;
        {pcW, pcWC, pcS, srcA, lao, lra, lrb, rw, m2r, imr, irw, dreq, dop, lmdr, ill} = '0;
        srcB = 2'd0;
        op   = OP_SUM;
        f3   = ir[14:12];
        case (st)
            S_FETCH:    begin imr = 1; if (last) begin irw = 1; pcW = 1; srcB = 2'd1; end end
            S_DECODE:   begin lra = 1; lrb = 1; lao = 1; srcB = 2'd3; end
            S_MEM_ADDR: begin lao = 1; srcA = 1; srcB = 2'd2; end
            S_MEM_LD:   begin dreq = 1; lmdr = last; end
            S_MEM_SD:   begin dreq = 1; dop = 1; end
            S_LD_WB:    begin rw = 1; m2r = 1; end
            S_EXEC_R:   begin srcA = 1; lao = 1; op = (f3 == 3'b000) ? (ir[30] ? OP_SUB : OP_SUM) : f3; end
            S_EXEC_I:   begin srcA = 1; srcB = 2'd2; lao = 1; op = f3; end
            S_EXEC_U:   begin srcB = 2'd2; lao = 1; op = OP_LOAD; end
            S_ALU_WB:   rw = 1;
            S_BRANCH:   begin srcA = 1; op = OP_SUB; pcS = 1; pcWC = (f3 == 3'b000) ? zero : !zero; end
            S_TRAP:     ill = 1;
            default:    ;
        endcase
        return {pcW, pcWC, pcS, srcA, srcB, op, lao, lra, lrb, rw, m2r, imr, irw, dreq, dop, lmdr, ill};
    endfunction

    // Appends a memory wait of the given latency; returns 1 when it times out into TRAP
    function automatic bit addWait(int st, int lat);
        int n;
        n = (lat > int'(MEM_TIMEOUT)) ? int'(MEM_TIMEOUT) + 1 : lat + 1;
        for (int k = 0; k < n; k++) begin
            pathState.push_back(st);
            pathLast.push_back((k == n - 1) && (lat <= int'(MEM_TIMEOUT)));
        end
        return lat > int'(MEM_TIMEOUT);
    endfunction

    function automatic void addTrap();
        repeat (3) begin pathState.push_back(S_TRAP); pathLast.push_back(1'b0); end
    endfunction

    // Instruction-level model: the sequence of states one instruction walks through
    function automatic bit buildPath(logic [31:0] ir, int imemLat, int dmemLat, bit atStart);
        pathState.delete();
        pathLast.delete();
        if (atStart) begin pathState.push_back(S_START); pathLast.push_back(1'b0); end
        if (addWait(S_FETCH, imemLat)) begin addTrap(); return 1'b1; end
        pathState.push_back(S_DECODE); pathLast.push_back(1'b0);
        case (ir[6:0])
            OPC_LOAD, OPC_STORE: begin
                pathState.push_back(S_MEM_ADDR); pathLast.push_back(1'b0);
                if (addWait((ir[6:0] == OPC_LOAD) ? S_MEM_LD : S_MEM_SD, dmemLat)) begin
                    addTrap(); return 1'b1;
                end
                if (ir[6:0] == OPC_LOAD) begin pathState.push_back(S_LD_WB); pathLast.push_back(1'b0); end
            end
            OPC_OPIMM, OPC_OP, OPC_LUI: begin
                pathState.push_back((ir[6:0] == OPC_OPIMM) ? S_EXEC_I : (ir[6:0] == OPC_OP) ? S_EXEC_R : S_EXEC_U);
                pathLast.push_back(1'b0);
                pathState.push_back(S_ALU_WB); pathLast.push_back(1'b0);
            end
            OPC_BRANCH: begin
                if (ir[14:13] != 2'b00) begin addTrap(); return 1'b1; end
                pathState.push_back(S_BRANCH); pathLast.push_back(1'b0);
            end
            default: begin addTrap(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    task automatic do_reset(int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        retiredModel = 0;
    endtask

    // Runs one instruction (or its first stopAt cycles); called at posedge+1 of its first cycle
    task automatic run_instr(input logic [31:0] ir, input int imemLat, input int dmemLat, input bit zero,
                             input bit atStart, input string name, input int stopAt, output bit trapped);
        logic [19:0] expCtl;
        int          n;
        trapped = buildPath(ir, imemLat, dmemLat, atStart);
        n = (stopAt >= 0 && stopAt < pathState.size()) ? stopAt : pathState.size();
        for (int i = 0; i < n; i++) begin
            bus.instruction = ir;
            bus.imem_ready  = (pathState[i] == S_FETCH) ? pathLast[i] : 1'($urandom);
            bus.dmem_ready  = (pathState[i] == S_MEM_LD || pathState[i] == S_MEM_SD) ? pathLast[i] : 1'($urandom);
            bus.alu_zero    = (pathState[i] == S_BRANCH) ? zero : 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.state_out !== 4'(pathState[i])) begin
                errors++;
                $display("FAIL %s state cyc%0d: got %0d expected %0d", name, i, bus.state_out, pathState[i]);
            end
            expCtl = expectedCtl(pathState[i], pathLast[i], zero, ir);
            checks++;
            if (actualCtl() !== expCtl) begin
                errors++;
                $display("FAIL %s ctl cyc%0d st%0d: got %020b expected %020b", name, i, pathState[i], actualCtl(), expCtl);
            end
            @(posedge clk);
            #1;
        end
        if (!trapped && n == pathState.size()) retiredModel++;
`ifdef CONTROL_RETIRE_COUNT_EN
        checks++;
        if (bus.retired !== 32'(retiredModel)) begin
            errors++;
            $display("FAIL %s retired: got %0d expected %0d", name, bus.retired, retiredModel);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.state_out !== 4'd0) begin errors++; $display("FAIL reset state: got %0d expected 0", bus.state_out); end
            checks++;
            if (actualCtl() !== 20'd0) begin errors++; $display("FAIL reset ctl: got %020b expected 0", actualCtl()); end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        retiredModel = 0;
    endtask

    task automatic test_addi();
        bit t;
        do_reset(2);
        run_instr(I_ADDI, 0, 0, 1'b0, 1'b1, "addi", -1, t);
        bus.imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state_out !== 4'(S_FETCH)) begin errors++; $display("FAIL addi refetch: got %0d expected 1", bus.state_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_delay();
        bit t;
        do_reset(2);
        run_instr(I_LD, 0, 3, 1'b0, 1'b1, "ld_delay", -1, t);
        run_instr(I_SD, 2, 3, 1'b0, 1'b0, "sd_delay", -1, t);
    endtask

    task automatic test_branch();
        bit t;
        do_reset(2);
        run_instr(I_BEQ, 0, 0, 1'b1, 1'b1, "beq_z1", -1, t);
        run_instr(I_BNE, 0, 0, 1'b1, 1'b0, "bne_z1", -1, t);
        run_instr(I_BEQ, 1, 0, 1'b0, 1'b0, "beq_z0", -1, t);
        run_instr(I_BNE, 0, 0, 1'b0, 1'b0, "bne_z0", -1, t);
    endtask

    task automatic test_timeout();
        bit t;
        do_reset(2);
        run_instr(I_ADDI, 40, 0, 1'b0, 1'b1, "imem_timeout", -1, t);
        do_reset(1);
        @(negedge clk);
        checks++;
        if (bus.illegal !== 1'b0 || bus.state_out !== 4'd0) begin
            errors++;
            $display("FAIL trap_clear: got illegal=%0b state=%0d expected 0/0", bus.illegal, bus.state_out);
        end
        @(posedge clk);
        #1;
        do_reset(2);
        run_instr(I_LD, 0, 16, 1'b0, 1'b1, "dmem_timeout", -1, t);
    endtask

    task automatic test_ready_boundary();
        bit t;
        do_reset(2);
        run_instr(I_LD, 15, 15, 1'b0, 1'b1, "ld_edge", -1, t);
        run_instr(I_SD, 15, 15, 1'b0, 1'b0, "sd_edge", -1, t);
    endtask

    task automatic test_illegal_opcode();
        bit t;
        do_reset(2);
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b1, "opc_7f", -1, t);
        do_reset(2);
        run_instr({17'd0, 3'b010, 5'd0, OPC_BRANCH}, 0, 0, 1'b0, 1'b1, "bad_branch", -1, t);
    endtask

    task automatic test_reset_midop();
        bit t;
        do_reset(2);
        run_instr(I_LD, 0, 5, 1'b0, 1'b1, "ld_abort", 5, t);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.state_out !== 4'(S_MEM_LD)) begin
            errors++;
            $display("FAIL abort_pre: got req=%0b state=%0d expected 1/9", bus.dmem_req, bus.state_out);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        retiredModel = 0;
        @(negedge clk);
        checks++;
        if (actualCtl() !== 20'd0 || bus.state_out !== 4'd0) begin
            errors++;
            $display("FAIL abort_post: got ctl=%020b state=%0d expected 0/0", actualCtl(), bus.state_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_retire_count();
        bit t;
        do_reset(2);
        run_instr(I_ADDI, 0, 0, 1'b0, 1'b1, "ret_addi", -1, t);
        run_instr(I_SD, 1, 2, 1'b0, 1'b0, "ret_sd", -1, t);
        run_instr(I_BNE, 0, 0, 1'b0, 1'b0, "ret_bne", -1, t);
        run_instr(I_ADDI, 0, 0, 1'b0, 1'b0, "ret_partial", 2, t);
        do_reset(1);
`ifdef CONTROL_RETIRE_COUNT_EN
        checks++;
        if (bus.retired !== 32'd0) begin errors++; $display("FAIL retire_reset: got %0d expected 0", bus.retired); end
`endif
    endtask

    task automatic test_random();
        bit          t;
        bit          atStart;
        logic [31:0] ir;
        logic [6:0]  opc;
        int          imemLat, dmemLat;
        do_reset(2);
        atStart = 1'b1;
        for (int it = 0; it < 60; it++) begin
            ir = $urandom;
            case ($urandom_range(0, 7))
                0: ir[6:0] = OPC_LOAD;
                1: ir[6:0] = OPC_STORE;
                2: ir[6:0] = OPC_OPIMM;
                3, 4: ir[6:0] = OPC_OP;
                5: ir[6:0] = OPC_LUI;
                6: begin ir[6:0] = OPC_BRANCH; ir[14:13] = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00; end
                default: begin
                    do opc = 7'($urandom);
                    while (opc inside {OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_LUI, OPC_BRANCH});
                    ir[6:0] = opc;
                end
            endcase
            imemLat = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            dmemLat = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            run_instr(ir, imemLat, dmemLat, 1'($urandom), atStart, "random", -1, t);
            atStart = 1'b0;
            if (t) begin
                do_reset($urandom_range(1, 2));
                atStart = 1'b1;
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.instruction = 32'd0;
        bus.alu_zero    = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.dmem_ready  = 1'b0;
        test_reset();
        test_addi();
        test_load_delay();
        test_branch();
        test_timeout();
        test_ready_boundary();
        test_illegal_opcode();
        test_reset_midop();
        test_retire_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised next-generation multicycle control FSM for the RV64 subset datapath (`processing`).
- Decodes the instruction register and sequences fetch/decode/execute/memory/writeback, driving all datapath control flags.
- Adds to the previous generation:
  - synchronous reset;
  - ready-based memory handshakes with bounded wait;
  - BEQ/BNE branch resolution via ALU zero;
  - an illegal-instruction trap state.

Parameters:
- ALU_OP_W, 3, width of alu_op; codes are taken from the operations package.
- MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before trapping; 0 = wait forever.
- CNT_W, 8, width of the wait counter; CNT_W must be large enough to hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instruction  in  32  IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
- alu_zero  in  1  ALU result == 0 (valid in BRANCH)
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  conditional PC load (branch taken)
- pc_source  out  1  0 = ALU result, 1 = ALU-out register
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = imm, 3 = imm<<1
- alu_op  out  ALU_OP_W  ALU operation
- load_a_out  out  1  latch ALU-out register
- load_reg_a / load_reg_b  out  1 each  latch regfile read ports
- reg_write  out  1  regfile write enable
- mem_to_reg  out  1  1 = MDR, 0 = ALU-out
- imem_read  out  1  instruction fetch request
- ir_write  out  1  latch IR
- dmem_req  out  1  data memory request
- dmem_op  out  1  0 = read, 1 = write
- load_mdr  out  1  latch MDR
- illegal  out  1  sticky trap flag
- state_out  out  4  current state encoding, for debug

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- On reset, the next state is START and all outputs are 0 (alu_op = SUM). Reset mid-operation aborts immediately; memory requests drop on the next edge.
- All outputs are combinational from the current state and inputs; each output defaults to 0 in every state that does not assert it.
- Wait counter:
  - Clears on entry to FETCH and MEM_LD/MEM_SD.
  - Increments each cycle the awaited ready is low.
  - When MEM_TIMEOUT != 0 and the counter == MEM_TIMEOUT with ready still low, the FSM goes to TRAP.
- State encodings: START=0, FETCH=1, DECODE=2, MEM_ADDR=3, EXEC_R=4, EXEC_I=5, EXEC_U=6, ALU_WB=7, BRANCH=8, MEM_LD=9, MEM_SD=10, LD_WB=11, TRAP=15.
- START → FETCH.
- FETCH:
  - imem_read=1.
  - If imem_ready: ir_write=1, pc_write=1, alu_src_a=PC, alu_src_b=4, alu_op=SUM; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - load_reg_a=1, load_reg_b=1, load_a_out=1, alu_src_a=PC, alu_src_b=imm<<1, alu_op=SUM (precomputes the branch target).
  - Dispatch on opcode:
    - 0000011 or 0100011 → MEM_ADDR
    - 0010011 → EXEC_I
    - 0110011 → EXEC_R
    - 0110111 → EXEC_U
    - 1100011 with funct3 000 or 001 → BRANCH
    - anything else → TRAP
- MEM_ADDR: load_a_out=1, alu_src_a=reg A, alu_src_b=imm, SUM. Next state MEM_LD if opcode is 0000011, else MEM_SD.
- MEM_LD: dmem_req=1, dmem_op=0. When dmem_ready: load_mdr=1, next state LD_WB.
- MEM_SD: dmem_req=1, dmem_op=1. When dmem_ready: next state FETCH.
- LD_WB: reg_write=1, mem_to_reg=1; next state FETCH.
- EXEC_R:
  - reg A op reg B; alu_op=SUB if funct7[5], else SUM for funct3=000; otherwise alu_op=funct3[ALU_OP_W-1:0].
  - load_a_out=1; next state ALU_WB.
- EXEC_I: reg A op imm; alu_op=funct3[ALU_OP_W-1:0]; load_a_out=1; next state ALU_WB.
- EXEC_U: alu_src_b=imm, alu_op=LOAD, load_a_out=1; next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; next state FETCH.
- BRANCH:
  - alu_src_a=reg A, alu_src_b=reg B, alu_op=SUB, pc_source=1.
  - pc_write_cond = alu_zero for BEQ, !alu_zero for BNE.
  - Next state FETCH.
- TRAP:
  - illegal=1; all other outputs 0.
  - The FSM stays in TRAP until reset; only reset clears illegal.
- imem_ready or dmem_ready asserted in the same cycle the counter hits MEM_TIMEOUT: ready wins and no trap is taken.

Optional Feature:
- CONTROL_RETIRE_COUNT_EN.
- When defined:
  - Adds output retired [31:0], reset to 0.
  - Increments by 1 on each transition into FETCH from LD_WB, MEM_SD, ALU_WB or BRANCH.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: no port and no counter logic.

Test Plan:
- Reset held 2 cycles, then released with imem_ready=1 and IR=ADDI x1,x0,5 (0x00500093) → state sequence 0,1,2,5,7,1; reg_write=1 only in ALU_WB.
- LD with dmem_ready delayed 3 cycles → MEM_LD lasts 4 cycles with dmem_req=1, dmem_op=0; load_mdr=1 only on the ready cycle; then LD_WB asserts mem_to_reg=1.
- BEQ with alu_zero=1 → pc_write_cond=1 and pc_source=1 in BRANCH. BNE with alu_zero=1 → pc_write_cond=0.
- MEM_TIMEOUT=15, imem_ready stuck at 0 → TRAP entered on the cycle after the counter reaches 15; illegal=1 persists until reset.
- Opcode 0x7F → DECODE → TRAP; state_out=15.
- CONTROL_RETIRE_COUNT_EN defined, 3 instructions completed (ADDI, SD, BNE) → retired=3; reset mid-ADDI → retired=0.
